apb_uart_rx: RTL and testbench
==============================

APB_UART_RX -- requirements
Module: apb_uart_rx

Interface
REQ-001 Parameter BUS_WIDTH, default 16: APB address width.
REQ-002 Parameter DATA_WIDTH, default 16: APB data width.
REQ-003 Parameter ADDR_EXP, default 4: the receive FIFO holds 2^ADDR_EXP bytes.
REQ-004 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; minimum 4.
REQ-005 clk  in  1  the single clock; all state updates on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 S_PADDR  in  BUS_WIDTH  APB address; only bits [1:0] are decoded.
REQ-008 S_PWRITE  in  1  APB write strobe.
REQ-009 S_PSELx  in  1  APB slave select.
REQ-010 S_PENABLE  in  1  APB access phase.
REQ-011 S_PWDATA  in  DATA_WIDTH  APB write data.
REQ-012 S_PRDATA  out  DATA_WIDTH  APB read data.
REQ-013 S_PREADY  out  1  APB ready.
REQ-014 rx_wire  in  1  asynchronous serial input, idle high, 8N1 format.
REQ-015 int_out  out  1  level interrupt, high while the FIFO is non-empty.

Function
REQ-016 The APB slave SHALL be zero-wait: S_PREADY = S_PSELx & S_PENABLE; S_PRDATA is valid while S_PREADY is high and 0 otherwise.
REQ-017 Register map on S_PADDR[1:0]:
- 0 DATA (RO): {zero-extend, FIFO head byte}; reads 0 when empty.
- 1 STATUS: {..., overrun[3], frame_err[2], full[1], empty[0]}. A write with bit n set clears sticky bit n, for n = 2, 3.
- 2 COUNT (RO): FIFO occupancy, 0..2^ADDR_EXP.
- 3 reads 0; writes ignored.
REQ-018 A completed DATA read (PSEL & PENABLE & !PWRITE & addr 0 & !empty) SHALL pop the FIFO at that clock edge; a read when empty pops nothing.
REQ-019 rx_wire SHALL pass through a 2-flop synchronizer; the receiver uses only the synchronized value (rx_s).
REQ-020 Receiver FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-021 IDLE: when rx_s = 0, go to START and clear the bit counter.
REQ-022 START: after CLKS_PER_BIT/2 cycles, sample rx_s. If 0, go to DATA. If 1, treat it as a glitch and return to IDLE with no flag set.
REQ-023 DATA: sample rx_s every CLKS_PER_BIT cycles, LSB first, for 8 bits, then go to STOP.
REQ-024 STOP: sample rx_s after CLKS_PER_BIT cycles.
- If 1: push the byte and go to IDLE.
- If 0: drop the byte, set frame_err, and go to WAIT_HIGH.
REQ-025 WAIT_HIGH: remain until rx_s = 1, then go to IDLE.
REQ-026 A push SHALL occur on the edge at which the stop bit is sampled high; empty deasserts and int_out asserts on the next cycle.
REQ-027 A push when full with no same-cycle pop SHALL drop the byte and set overrun; FIFO contents are unchanged.
REQ-028 A simultaneous push and pop SHALL both take effect; the count is unchanged, including when the FIFO is full.
REQ-029 FIFO read and write pointers SHALL be ADDR_EXP bits and wrap modulo 2^ADDR_EXP; the count is ADDR_EXP+1 bits.
REQ-030 A sticky-clear write in the same cycle as a new error event SHALL leave the flag set.

Reset
REQ-031 On reset, these SHALL take the following values:
- FSM: IDLE; counters: 0.
- FIFO: empty, pointers and count 0.
- overrun and frame_err: 0.
- Synchronizer flops: 1.
- int_out: 0; S_PRDATA: 0; S_PREADY: 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no push and no flag set; the receiver resumes at the next falling edge of rx_s.

Verification (CLKS_PER_BIT = 16, ADDR_EXP = 4)
REQ-033 Send 0xA5 with a valid frame -> int_out rises one cycle after the stop sample; COUNT = 1; DATA read returns 0x00A5; afterwards COUNT = 0 and int_out = 0.
REQ-034 Send 17 bytes 0x00..0x10 with no reads -> COUNT = 16, full = 1, overrun = 1; 16 reads return 0x00..0x0F in order.
REQ-035 Send 0x3C with the stop bit held low for 40 bit times -> frame_err = 1 and COUNT = 0; then send 0x55 -> received correctly; write 0x0004 to STATUS -> frame_err = 0.
REQ-036 Drive a 5-cycle low pulse on rx_wire -> no push, no flags set, FSM returns to IDLE.
REQ-037 With the FIFO full, issue a DATA read on the same edge as the stop-bit sample -> COUNT stays 16, overrun = 0, the new byte is last in order.
REQ-038 Assert reset during DATA bit 4 of a frame -> COUNT = 0 and no flags set; the following frame 0x81 is received intact.

Source files
------------

// File: rtl/apb_uart_rx.sv
// APB-mapped 8N1 UART receiver with a power-of-two byte FIFO.
// Sticky overrun/frame-error flags; int_out stays high while the FIFO holds data.
module apb_uart_rx #(
  parameter int BUS_WIDTH    = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_EXP     = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BUS_WIDTH-1:0]  S_PADDR,
  input  logic                  S_PWRITE,
  input  logic                  S_PSELx,
  input  logic                  S_PENABLE,
  input  logic [DATA_WIDTH-1:0] S_PWDATA,
  output logic [DATA_WIDTH-1:0] S_PRDATA,
  output logic                  S_PREADY,
  input  logic                  rx_wire,
  output logic                  int_out
);

  localparam int DEPTH = 1 << ADDR_EXP;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  HALF_M1   = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  FULL_M1   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_EXP:0] DEPTH_CNT = (ADDR_EXP + 1)'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_t;

  logic                rx_p0;
  logic                rx_p1;
  logic                rx_s;

  rx_state_t           state;
  rx_state_t           state_nxt;
  logic [CNT_W-1:0]    clk_cnt;
  logic [2:0]          bit_cnt;
  logic [7:0]          rx_byte;

  logic                cnt_clr;
  logic                cnt_inc;
  logic                bit_clr;
  logic                bit_inc;
  logic                shift_en;
  logic                push_req;
  logic                frame_set;

  logic [7:0]          mem [DEPTH];
  logic [ADDR_EXP-1:0] wr_ptr;
  logic [ADDR_EXP-1:0] rd_ptr;
  logic [ADDR_EXP:0]   count;
  logic                empty;
  logic                full;
  logic                push;
  logic                pop;
  logic                ovr_set;

  logic                overrun;
  logic                frame_err;

  logic                apb_access;
  logic                rd_data;
  logic                wr_status;
  logic                clr_frame;
  logic                clr_ovr;
  logic [7:0]          head;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                unused_bits;

  // Stage p0/p1: two-flop synchronizer; idles high so reset never fakes a start bit
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx_wire;
      rx_p1 <= rx_p0;
    end
  end

  assign rx_s = rx_p1;

  // Receiver FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    bit_clr   = 1'b0;
    bit_inc   = 1'b0;
    shift_en  = 1'b0;
    push_req  = 1'b0;
    frame_set = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (!rx_s) begin
          state_nxt = ST_START;
          bit_clr   = 1'b1;
        end
      end
      ST_START: begin
        if (clk_cnt == HALF_M1) begin
          cnt_clr   = 1'b1;
          // A line already back high at mid start bit is a glitch, not a frame
          state_nxt = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_DATA: begin
        if (clk_cnt == FULL_M1) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          bit_inc  = 1'b1;
          if (bit_cnt == 3'd7) begin
            state_nxt = ST_STOP;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_STOP: begin
        if (clk_cnt == FULL_M1) begin
          cnt_clr = 1'b1;
          if (rx_s) begin
            push_req  = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            frame_set = 1'b1;
            state_nxt = ST_WAIT_HIGH;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_WAIT_HIGH: begin
        cnt_clr = 1'b1;
        if (rx_s) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      if (cnt_clr) begin
        clk_cnt <= '0;
      end else if (cnt_inc) begin
        clk_cnt <= clk_cnt + 1'b1;
      end
      if (bit_clr) begin
        bit_cnt <= '0;
      end else if (bit_inc) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // LSB arrives first, so shift in from the top
  always_ff @(posedge clk) begin
    if (shift_en) begin
      rx_byte <= {rx_s, rx_byte[7:1]};
    end
  end

  // FIFO: a pop in the same cycle frees the slot a full-FIFO push needs
  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);
  assign pop     = rd_data & !empty;
  assign push    = push_req & (!full | pop);
  assign ovr_set = push_req & full & !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= rx_byte;
    end
  end

  assign head    = empty ? 8'h00 : mem[rd_ptr];
  assign int_out = !empty;

  // Sticky flags: a new event wins over a coincident clear
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= ovr_set | (overrun & !clr_ovr);
      frame_err <= frame_set | (frame_err & !clr_frame);
    end
  end

  // APB slave: zero wait states, read data gated to the access phase
  assign apb_access = S_PSELx & S_PENABLE;
  assign S_PREADY   = apb_access;
  assign rd_data    = apb_access & !S_PWRITE & (S_PADDR[1:0] == 2'd0);
  assign wr_status  = apb_access & S_PWRITE & (S_PADDR[1:0] == 2'd1);
  assign clr_frame  = wr_status & S_PWDATA[2];
  assign clr_ovr    = wr_status & S_PWDATA[3];

  always_comb begin
    rd_word = '0;
    case (S_PADDR[1:0])
      2'd0:    rd_word[7:0]        = head;
      2'd1:    rd_word[3:0]        = {overrun, frame_err, full, empty};
      2'd2:    rd_word[ADDR_EXP:0] = count;
      default: rd_word             = '0;
    endcase
  end

  assign S_PRDATA = S_PREADY ? rd_word : '0;

  assign unused_bits = ^{S_PADDR[BUS_WIDTH-1:2], S_PWDATA[DATA_WIDTH-1:4], S_PWDATA[1:0]};

endmodule

// File: tb/tb_apb_uart_rx.sv
// Directed + randomized bench for apb_uart_rx; expected FIFO contents and flags
// come from a queue-based model of the receiver's documented behaviour.
module tb_apb_uart_rx;

  localparam int CPB   = 16;
  localparam int AE    = 4;
  localparam int DEPTH = 16;
  localparam int BW    = 16;
  localparam int DW    = 16;
  // Start bit launched just after edge 0 is detected 2 sync edges + 1 idle edge later,
  // sampled mid-bit, then nine full bit periods to the stop sample.
  localparam int STOP_EDGE = 3 + CPB / 2 + 9 * CPB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [BW-1:0] paddr = '0;
  logic          pwrite = 1'b0;
  logic          psel = 1'b0;
  logic          penable = 1'b0;
  logic [DW-1:0] pwdata = '0;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          rx_wire = 1'b1;
  logic          int_out;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] q[$];
  logic       m_ovr = 1'b0;
  logic       m_fe = 1'b0;

  apb_uart_rx #(
    .BUS_WIDTH(BW), .DATA_WIDTH(DW), .ADDR_EXP(AE), .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk), .reset(reset),
    .S_PADDR(paddr), .S_PWRITE(pwrite), .S_PSELx(psel), .S_PENABLE(penable),
    .S_PWDATA(pwdata), .S_PRDATA(prdata), .S_PREADY(pready),
    .rx_wire(rx_wire), .int_out(int_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apb_read(input logic [1:0] a, output logic [DW-1:0] d);
    paddr = BW'($urandom);
    paddr[1:0] = a;
    pwrite = 1'b0;
    psel = 1'b1;
    penable = 1'b0;
    #1 check("prdata_setup", 32'(prdata), 32'h0);
    @(negedge clk);
    penable = 1'b1;
    #1 d = prdata;
    check("pready", 32'(pready), 32'h1);
    @(negedge clk);
    psel = 1'b0;
    penable = 1'b0;
  endtask

  task automatic apb_write(input logic [1:0] a, input logic [DW-1:0] wd);
    paddr = BW'($urandom);
    paddr[1:0] = a;
    pwrite = 1'b1;
    pwdata = wd;
    psel = 1'b1;
    penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0;
    penable = 1'b0;
    pwrite = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_val, input int stop_bits);
    rx_wire = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_wire = b[i];
      cycles(CPB);
    end
    rx_wire = stop_val;
    cycles(CPB * stop_bits);
    rx_wire = 1'b1;
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[0] = (q.size() == 0);
    s[1] = (q.size() == DEPTH);
    s[2] = m_fe;
    s[3] = m_ovr;
    return s;
  endfunction

  function automatic void model_good(input logic [7:0] b);
    if (q.size() == DEPTH) m_ovr = 1'b1;
    else q.push_back(b);
  endfunction

  task automatic check_regs(input string tag);
    logic [DW-1:0] d;
    apb_read(2'd2, d);
    check({tag, "_count"}, 32'(d), 32'(q.size()));
    apb_read(2'd1, d);
    check({tag, "_status"}, 32'(d), exp_status());
    check({tag, "_int"}, 32'(int_out), 32'(q.size() != 0));
  endtask

  task automatic read_pop(input string tag);
    logic [DW-1:0] d;
    logic [7:0]    e;
    e = (q.size() != 0) ? q.pop_front() : 8'h00;
    apb_read(2'd0, d);
    check(tag, 32'(d), 32'(e));
  endtask

  initial begin
    #(10 * 150000);
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [DW-1:0] d;
    logic [7:0]    b;
    logic [7:0]    e;
    logic [DW-1:0] w;
    logic          bad;

    // Reset values
    cycles(3);
    check("rst_int", 32'(int_out), 32'h0);
    check("rst_prdata", 32'(prdata), 32'h0);
    check("rst_pready", 32'(pready), 32'h0);
    reset = 1'b0;
    cycles(2);
    check_regs("rst");
    apb_write(2'd3, 16'hFFFF);
    apb_read(2'd3, d);
    check("addr3", 32'(d), 32'h0);
    read_pop("empty_read");
    check_regs("after_empty_read");

    // Single byte with interrupt timing
    fork
      send_frame(8'hA5, 1'b1, 1);
      begin
        cycles(STOP_EDGE - 1);
        check("int_before_stop", 32'(int_out), 32'h0);
        cycles(1);
        check("int_after_stop", 32'(int_out), 32'h1);
      end
    join
    model_good(8'hA5);
    cycles(4);
    check_regs("one_byte");
    read_pop("data_a5");
    check_regs("one_byte_drained");

    // Overfill: 17 bytes into 16 slots
    for (int i = 0; i <= DEPTH; i++) begin
      send_frame(8'(i), 1'b1, 1);
      model_good(8'(i));
      cycles(2);
    end
    check_regs("overfill");
    for (int i = 0; i < DEPTH; i++) read_pop("fill_order");
    apb_write(2'd1, 16'h0008);
    m_ovr = 1'b0;
    check_regs("ovr_cleared");

    // Short low glitch must not start a frame
    rx_wire = 1'b0;
    cycles(5);
    rx_wire = 1'b1;
    cycles(40);
    check_regs("glitch");

    // Long break in place of the stop bit
    send_frame(8'h3C, 1'b0, 40);
    m_fe = 1'b1;
    cycles(20);
    check_regs("frame_err");
    send_frame(8'h55, 1'b1, 1);
    model_good(8'h55);
    cycles(4);
    read_pop("data_55");
    apb_write(2'd1, 16'h0004);
    m_fe = 1'b0;
    check_regs("fe_cleared");

    // Randomized frames, reads and flag clears
    for (int k = 0; k < 24; k++) begin
      b = 8'($urandom);
      bad = ($urandom_range(0, 4) == 0);
      send_frame(b, !bad, 1);
      if (bad) m_fe = 1'b1;
      else model_good(b);
      cycles(4 + $urandom_range(0, 20));
      for (int r = $urandom_range(0, 2); r > 0; r--) read_pop("rand_data");
      if ($urandom_range(0, 3) == 0) begin
        w = DW'($urandom_range(0, 15));
        apb_write(2'd1, w);
        if (w[2]) m_fe = 1'b0;
        if (w[3]) m_ovr = 1'b0;
      end
    end
    check_regs("rand_end");
    while (q.size() != 0) read_pop("rand_drain");
    apb_write(2'd1, 16'h000C);
    m_fe = 1'b0;
    m_ovr = 1'b0;
    check_regs("rand_drained");

    // Full FIFO: pop coinciding with the stop sample keeps the new byte
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, 1);
      model_good(b);
      cycles(2);
    end
    check_regs("refill");
    b = 8'($urandom);
    e = q.pop_front();
    q.push_back(b);
    fork
      send_frame(b, 1'b1, 1);
      begin
        cycles(STOP_EDGE - 2);
        apb_read(2'd0, d);
      end
    join
    check("pop_on_push_head", 32'(d), 32'(e));
    cycles(2);
    check_regs("pop_on_push");

    // Clear write landing on an overrun event leaves overrun set
    b = 8'($urandom);
    m_ovr = 1'b1;
    fork
      send_frame(b, 1'b1, 1);
      begin
        cycles(STOP_EDGE - 2);
        apb_write(2'd1, 16'h0008);
      end
    join
    cycles(2);
    check_regs("clear_vs_ovr");
    while (q.size() != 0) read_pop("full_order");
    apb_write(2'd1, 16'h0008);
    m_ovr = 1'b0;
    check_regs("ovr_cleared2");

    // Reset in the middle of data bit 4 discards everything
    send_frame(8'h11, 1'b1, 1);
    model_good(8'h11);
    cycles(4);
    send_frame(8'h22, 1'b0, 1);
    m_fe = 1'b1;
    cycles(4);
    check_regs("pre_reset");
    b = 8'h5A;
    rx_wire = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 4; i++) begin
      rx_wire = b[i];
      cycles(CPB);
    end
    rx_wire = b[4];
    cycles(CPB / 2);
    reset = 1'b1;
    cycles(3);
    check("midreset_int", 32'(int_out), 32'h0);
    reset = 1'b0;
    rx_wire = 1'b1;
    q.delete();
    m_fe = 1'b0;
    m_ovr = 1'b0;
    cycles(3 * CPB);
    check_regs("post_reset");
    send_frame(8'h81, 1'b1, 1);
    model_good(8'h81);
    cycles(4);
    check_regs("after_reset_frame");
    read_pop("data_81");
    check_regs("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
